// File: rtl/mult_seq_pkg.sv
// -----------------------------------------------------------------------------
// mult_seq_pkg
// Shared definitions for the sequential Booth multiplier and for any logic
// (ALU issue, stall control) that needs to track the multiplier's progress.
//   MULT_ITER    : default Booth iteration count (equals operand width)
//   mult_state_e : multiplier FSM state encoding
//   sext33       : sign-extend a 32-bit operand into the 33-bit accumulator
// -----------------------------------------------------------------------------
package mult_seq_pkg;

  localparam int MULT_ITER = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mult_state_e;

  function automatic logic [32:0] sext33(input logic [31:0] v);
    return {v[31], v};
  endfunction

endpackage

// File: rtl/mult_seq_cla.sv
// -----------------------------------------------------------------------------
// cla
// 32-bit adder built from eight 4-bit carry-lookahead groups, rippling the
// group carry between groups.
//   A, B     : addends
//   Cin      : carry in (used as the +1 of a two's complement subtract)
//   S        : 32-bit sum
//   prevCout : carry into bit 31 (for signed overflow detection by callers)
//   Cout     : carry out of bit 31
// -----------------------------------------------------------------------------
module cla (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cin,
  output logic [31:0] S,
  output logic        prevCout,
  output logic        Cout
);

  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;

  // Generate/propagate and per-group lookahead carries.
  always_comb begin
    g    = A & B;
    p    = A ^ B;
    c    = '0;
    c[0] = Cin;
    for (int blk = 0; blk < 8; blk++) begin
      c[blk*4+1] = g[blk*4] | (p[blk*4] & c[blk*4]);
      c[blk*4+2] = g[blk*4+1] | (p[blk*4+1] & g[blk*4])
                 | (p[blk*4+1] & p[blk*4] & c[blk*4]);
      c[blk*4+3] = g[blk*4+2] | (p[blk*4+2] & g[blk*4+1])
                 | (p[blk*4+2] & p[blk*4+1] & g[blk*4])
                 | (p[blk*4+2] & p[blk*4+1] & p[blk*4] & c[blk*4]);
      c[blk*4+4] = g[blk*4+3] | (p[blk*4+3] & g[blk*4+2])
                 | (p[blk*4+3] & p[blk*4+2] & g[blk*4+1])
                 | (p[blk*4+3] & p[blk*4+2] & p[blk*4+1] & g[blk*4])
                 | (p[blk*4+3] & p[blk*4+2] & p[blk*4+1] & p[blk*4] & c[blk*4]);
    end
    S        = p ^ c[31:0];
    prevCout = c[31];
    Cout     = c[32];
  end

endmodule

// File: rtl/mult_seq.sv
// -----------------------------------------------------------------------------
// mult_seq
// Sequential radix-2 Booth multiplier, one Booth step per clock, sharing a
// single 32-bit CLA for every add/subtract.
//   clock          : clock, all state on rising edge
//   reset          : synchronous active-high reset
//   ctrl_MULT      : start pulse, accepted only in IDLE
//   data_operandA  : multiplicand (two's complement)
//   data_operandB  : multiplier (two's complement)
//   data_result    : low 32 bits of product, held until the next completion
//   data_exception : product does not fit in signed 32 bits
//   data_resultRDY : one-cycle pulse in the DONE cycle
// Start in cycle 0 gives data_resultRDY in cycle ITER+1.
// -----------------------------------------------------------------------------
module mult_seq
  import mult_seq_pkg::*;
#(
  parameter int ITER = MULT_ITER
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  mult_state_e state_q, state_d;
  logic [5:0]  count_q, count_d;
  logic [32:0] acc_q, acc_d;
  logic [31:0] q_q, q_d;
  logic        qm1_q, qm1_d;
  logic [31:0] a_q, a_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;
  logic        rdy_q, rdy_d;

  logic [32:0] addend;
  logic        add_cin;
  logic [31:0] cla_sum;
  logic        cla_cout;
  logic        cla_prevcout_unused;
  logic        sum_msb;
  logic [32:0] sh_acc;
  logic [31:0] sh_q;

  // Booth recoding: pick +A, -A (as ~A + 1) or zero for this step.
  always_comb begin
    addend  = 33'd0;
    add_cin = 1'b0;
    case ({q_q[0], qm1_q})
      2'b01: begin
        addend  = sext33(a_q);
        add_cin = 1'b0;
      end
      2'b10: begin
        addend  = sext33(~a_q);
        add_cin = 1'b1;
      end
      default: begin
        addend  = 33'd0;
        add_cin = 1'b0;
      end
    endcase
  end

  cla u_cla (
    .A        (acc_q[31:0]),
    .B        (addend[31:0]),
    .Cin      (add_cin),
    .S        (cla_sum),
    .prevCout (cla_prevcout_unused),
    .Cout     (cla_cout)
  );

  // Bit 32 of the sum is rebuilt from the CLA carry; the 33-bit accumulator
  // keeps the -(-2^31) subtract from overflowing.
  always_comb begin
    sum_msb = acc_q[32] ^ addend[32] ^ cla_cout;
    sh_acc  = {sum_msb, sum_msb, cla_sum[31:1]};
    sh_q    = {cla_sum[0], q_q[31:1]};
  end

  // FSM next state, datapath next values and registered outputs.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    q_d      = q_q;
    qm1_d    = qm1_q;
    a_d      = a_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_MULT) begin
          a_d     = data_operandA;
          acc_d   = 33'd0;
          q_d     = data_operandB;
          qm1_d   = 1'b0;
          count_d = 6'd0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d   = sh_acc;
        q_d     = sh_q;
        qm1_d   = q_q[0];
        count_d = count_q + 6'd1;
        // Outputs are registered on the final step so they are valid in DONE.
        if (count_q == 6'(ITER - 1)) begin
          state_d  = ST_DONE;
          rdy_d    = 1'b1;
          result_d = sh_q;
          exc_d    = (sh_acc[31:0] != {32{sh_q[31]}});
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= 6'd0;
      acc_q    <= 33'd0;
      q_q      <= 32'd0;
      qm1_q    <= 1'b0;
      a_q      <= 32'd0;
      result_q <= 32'd0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      qm1_q    <= qm1_d;
      a_q      <= a_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_mult_seq.sv
// -----------------------------------------------------------------------------
// tb_mult_seq
// Directed-vector bench for mult_seq with hand-computed expected products.
// -----------------------------------------------------------------------------
module tb_mult_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int rdy_cyc = 0;
  logic [31:0] last_res = 32'd0;

  mult_seq dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; drives a start pulse for exactly one rising edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    data_operandA = 32'hA5A5A5A5;
    data_operandB = 32'h5A5A5A5A;
  endtask

  // Counts cycles after the start cycle until data_resultRDY; -1 on timeout.
  task automatic wait_rdy(output int lat);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clock);
      if (data_resultRDY) begin
        lat     = i;
        rdy_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ee);
    int lat;
    start_op(a, b);
    wait_rdy(lat);
    check_val({tag, "_lat"}, lat, 32'd33);
    check_val({tag, "_res"}, data_result, er);
    check_val({tag, "_exc"}, {31'd0, data_exception}, {31'd0, ee});
    last_res = er;
    @(negedge clock);
    check_val({tag, "_rdy_drop"}, {31'd0, data_resultRDY}, 32'd0);
  endtask

  initial begin
    int r1;
    int pulses;
    int first;
    int lat;
    logic [31:0] res;

    reset         = 1'b1;
    ctrl_MULT     = 1'b1;
    data_operandA = 32'd3;
    data_operandB = 32'd3;
    repeat (3) @(negedge clock);
    check_val("rst_res", data_result, 32'd0);
    check_val("rst_exc", {31'd0, data_exception}, 32'd0);
    check_val("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
    ctrl_MULT = 1'b0;
    reset     = 1'b0;
    @(negedge clock);

    run_op("basic", 32'd3, 32'd4, 32'd12, 1'b0);
    r1 = rdy_cyc;
    run_op("b2b", 32'd5, 32'd7, 32'd35, 1'b0);
    check_val("b2b_gap", rdy_cyc - r1, 32'd34);

    run_op("neg_pos", 32'hFFFFFFF9, 32'd6, 32'hFFFFFFD6, 1'b0);
    run_op("neg_neg", 32'hFFFFFFFB, 32'hFFFFFFFB, 32'd25, 1'b0);
    run_op("ovf_max", 32'h7FFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b1);
    run_op("ovf_min", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
    run_op("min_one", 32'h80000000, 32'd1, 32'h80000000, 1'b0);
    run_op("min_min", 32'h80000000, 32'h80000000, 32'd0, 1'b1);

    // Start while busy: second pulse in cycle 10 must be ignored.
    start_op(32'd2, 32'd3);
    pulses = 0;
    first  = -1;
    res    = 32'd0;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clock);
      if (i == 20) check_val("busy_hold", data_result, last_res);
      if (data_resultRDY) begin
        pulses++;
        if (first < 0) begin
          first = i;
          res   = data_result;
        end
      end
      if (i == 10) begin
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd9;
        data_operandB = 32'd9;
      end else begin
        ctrl_MULT = 1'b0;
      end
    end
    check_val("busy_pulses", pulses, 32'd1);
    check_val("busy_lat", first, 32'd33);
    check_val("busy_res", res, 32'd6);
    last_res = 32'd6;

    // Start coinciding with the DONE pulse must be ignored.
    start_op(32'd3, 32'd3);
    wait_rdy(lat);
    check_val("done_lat", lat, 32'd33);
    check_val("done_res", data_result, 32'd9);
    ctrl_MULT     = 1'b1;
    data_operandA = 32'd7;
    data_operandB = 32'd7;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    pulses = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clock);
      if (data_resultRDY) pulses++;
    end
    check_val("done_ign_pulses", pulses, 32'd0);
    check_val("done_ign_hold", data_result, 32'd9);

    // Reset mid-operation aborts and clears outputs.
    start_op(32'd5, 32'd5);
    repeat (15) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_val("midrst_res", data_result, 32'd0);
    check_val("midrst_exc", {31'd0, data_exception}, 32'd0);
    check_val("midrst_rdy", {31'd0, data_resultRDY}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clock);
      if (data_resultRDY) pulses++;
    end
    check_val("midrst_pulses", pulses, 32'd0);
    run_op("post_rst", 32'd5, 32'd5, 32'd25, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
